// File: rtl/cache_arbiter.sv
// Merges icache and dcache line-miss ports onto one adaptor port. CACHE_ARBITER_RR_EN selects round-robin ties.
// A grant drives the adaptor 1 cycle after the request. The grant is held until resp_i, and there is at least 1 idle cycle between grants.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] address_o,
  output logic [LINE_W-1:0] line_o,
  output logic              read_o,
  output logic              write_o,
  input  logic [LINE_W-1:0] line_i,
  input  logic              resp_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   last_grant_nxt;
  logic   i_req;
  logic   d_req;
  logic   tie_to_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
  // On a tie, grant the requester that was not served last.
  assign tie_to_d = (last_grant == ICACHE);
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ICACHE;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = tie_to_d ? SERVE_D : SERVE_I;
        else if (d_req)     state_nxt = SERVE_D;
        else if (i_req)     state_nxt = SERVE_I;
      end
      SERVE_I: begin
        if (resp_i) begin
          state_nxt      = IDLE;
          last_grant_nxt = ICACHE;
        end
      end
      SERVE_D: begin
        if (resp_i) begin
          state_nxt      = IDLE;
          last_grant_nxt = DCACHE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on the registered grant and the live inputs, so IDLE forces everything to zero.
  always_comb begin
    address_o = '0;
    line_o    = '0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    i_rdata   = '0;
    i_resp    = 1'b0;
    d_rdata   = '0;
    d_resp    = 1'b0;
    case (state)
      SERVE_I: begin
        address_o = i_address;
        read_o    = 1'b1;
        if (resp_i) begin
          i_resp  = 1'b1;
          i_rdata = line_i;
        end
      end
      SERVE_D: begin
        address_o = d_address;
        line_o    = d_wdata;
        write_o   = d_write;
        read_o    = d_read & ~d_write;
        if (resp_i) begin
          d_resp  = 1'b1;
          d_rdata = line_i;
        end
      end
      default: ;
    endcase
  end

endmodule
